// File: rtl/rmt_pkg.sv
// Shared pipeline constants and types used by the parser, stages, deparser
// and the PHV input arbiter.
package rmt_pkg;

    localparam int PKT_VEC_WIDTH = 1124;
    localparam int CREDIT_DEPTH  = 16;
    localparam int GRANT_CNT_W   = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;

endpackage : rmt_pkg

// File: rtl/phv_in_arb_if.sv
// Parser-to-pipeline handshake bundle for the PHV input arbiter.
// The arbiter uses the slave modport; the parsers/stage side uses master.
interface phv_in_arb_if #(
    parameter int PKT_VEC_WIDTH = rmt_pkg::PKT_VEC_WIDTH,
    parameter int CREDIT_DEPTH  = rmt_pkg::CREDIT_DEPTH,
    parameter int CNT_W         = rmt_pkg::GRANT_CNT_W
) ();
    import rmt_pkg::*;

    localparam int CRED_W = $clog2(CREDIT_DEPTH) + 1;

    logic [PKT_VEC_WIDTH-1:0] s0_phv_in;
    logic                     s0_phv_valid;
    logic                     s0_phv_ready;
    logic [PKT_VEC_WIDTH-1:0] s1_phv_in;
    logic                     s1_phv_valid;
    logic                     s1_phv_ready;
    logic [1:0]               port_en;
    logic                     credit_return;
    logic [PKT_VEC_WIDTH-1:0] phv_out;
    logic                     phv_out_valid;
    port_idx_t                phv_out_src;
    logic [CRED_W-1:0]        credit_avail;
    logic [CNT_W-1:0]         s0_grant_cnt;
    logic [CNT_W-1:0]         s1_grant_cnt;
    logic                     credit_err;

    modport master (
        output s0_phv_in, s0_phv_valid, s1_phv_in, s1_phv_valid, port_en, credit_return,
        input  s0_phv_ready, s1_phv_ready, phv_out, phv_out_valid, phv_out_src,
               credit_avail, s0_grant_cnt, s1_grant_cnt, credit_err
    );

    modport slave (
        input  s0_phv_in, s0_phv_valid, s1_phv_in, s1_phv_valid, port_en, credit_return,
        output s0_phv_ready, s1_phv_ready, phv_out, phv_out_valid, phv_out_src,
               credit_avail, s0_grant_cnt, s1_grant_cnt, credit_err
    );

endinterface : phv_in_arb_if

// File: rtl/phv_in_arb_rr_arb2.sv
// Combinational two-request round-robin grant: on contention the port that
// did not win last time is granted.
module rr_arb2
    import rmt_pkg::*;
(
    input  logic [1:0] i_req,
    input  port_idx_t  i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        // NOTE: assign a default first so every path drives o_gnt and no latch is inferred.
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last_grant == PORT1) ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_arb2

// File: rtl/phv_in_arb.sv
// Two-parser PHV input arbiter: round-robin grant, credit flow control toward
// the downstream PHV FIFO, one-cycle registered output and per-port statistics.
module phv_in_arb #(
    parameter int PKT_VEC_WIDTH = rmt_pkg::PKT_VEC_WIDTH,
    parameter int CREDIT_DEPTH  = rmt_pkg::CREDIT_DEPTH,
    parameter int CNT_W         = rmt_pkg::GRANT_CNT_W
) (
    input logic         clk,
    input logic         rst,
    phv_in_arb_if.slave bus
);
    import rmt_pkg::*;

    localparam int                CRED_W    = $clog2(CREDIT_DEPTH) + 1;
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDIT_DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [CRED_W-1:0]        r_credit;
    logic                     r_err;
    port_idx_t                r_last_grant;
    logic                     r_valid;
    logic [PKT_VEC_WIDTH-1:0] r_phv;
    port_idx_t                r_src;
    logic [CNT_W-1:0]         r_cnt0;
    logic [CNT_W-1:0]         r_cnt1;

    logic                     w_can_grant;
    logic [1:0]               w_req;
    logic [1:0]               w_gnt;
    logic                     w_xfer;
    port_idx_t                w_gnt_idx;

    // A credit returned while empty only becomes usable once it is registered.
    assign w_can_grant = (r_credit != '0) && !rst;
    assign w_req       = {bus.s1_phv_valid & bus.port_en[1],
                          bus.s0_phv_valid & bus.port_en[0]} & {2{w_can_grant}};

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    assign w_xfer    = |w_gnt;
    assign w_gnt_idx = w_gnt[1] ? PORT1 : PORT0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_credit <= CRED_FULL;
            r_err    <= 1'b0;
        end else begin
            case ({w_xfer, bus.credit_return})
                2'b10:   r_credit <= r_credit - CRED_ONE;
                2'b01: begin
                    if (r_credit == CRED_FULL) r_err    <= 1'b1;
                    else                       r_credit <= r_credit + CRED_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the wide PHV register is reset too because its reset value is observable on phv_out.
        if (rst) begin
            r_valid      <= 1'b0;
            r_phv        <= '0;
            r_src        <= PORT0;
            r_last_grant <= PORT1;
        end else begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_phv        <= w_gnt[1] ? bus.s1_phv_in : bus.s0_phv_in;
                r_src        <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt[0] && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_ONE;
            if (w_gnt[1] && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_ONE;
        end
    end

    assign bus.s0_phv_ready  = w_gnt[0];
    assign bus.s1_phv_ready  = w_gnt[1];
    assign bus.phv_out       = r_phv;
    assign bus.phv_out_valid = r_valid & !rst;
    assign bus.phv_out_src   = r_src;
    assign bus.credit_avail  = r_credit;
    assign bus.s0_grant_cnt  = r_cnt0;
    assign bus.s1_grant_cnt  = r_cnt1;
    assign bus.credit_err    = r_err;

endmodule : phv_in_arb
